// File: rtl/gpp16_pkg.sv
// gpp16_pkg -- shared definitions for the GPP16 memory responder slice.
//   DATA_W           : width of a memory word (16 bits)
//   DEF_ADDR_W       : default word-address width
//   DEF_DEPTH        : default number of implemented words
//   DEF_WAIT_CYCLES  : default number of inserted wait states
//   state_t          : responder FSM state (IDLE / WAIT / RESP)
package gpp16_pkg;

  localparam int DATA_W          = 16;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DEPTH       = 192;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/gpp16_mem_responder_if.sv
// gpp16_mem_responder_if -- CPU-to-memory request/response bus.
//   req_valid/req_ready : request handshake; req_we/req_addr/req_wdata qualify it
//   rsp_valid/rsp_ready : response handshake; rsp_rdata/rsp_err qualify it
// Handshake rule (both channels): a transfer happens at a rising clock edge
// where valid and ready are both high. The payload must be stable while valid
// is high and ready is low; the receiver never depends on valid to raise ready.
// Modports: master = CPU side, slave = memory responder side.
interface gpp16_mem_responder_if
  import gpp16_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/gpp16_sp_ram.sv
// gpp16_sp_ram -- single-port DEPTH x 16 storage array.
//   clk   : clock
//   en    : access enable for this edge
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address (caller guarantees addr < DEPTH when en=1)
//   wdata : write data
//   rdata : registered read data; holds its value until the next read
// Contents are never reset.
module gpp16_sp_ram
  import gpp16_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/gpp16_mem_responder.sv
// gpp16_mem_responder -- wait-state memory responder for the GPP16 CPU.
//   clk       : clock, all registers update on the rising edge
//   rst       : synchronous active-high reset (memory contents untouched)
//   bus       : slave side of gpp16_mem_responder_if (request/response channels)
//   dbg_state : current FSM state, for observation only
// Parameters: ADDR_W (word address width), DEPTH (implemented words),
//             WAIT_CYCLES (inserted wait states, 0..15).
// A request is accepted in IDLE, waits WAIT_CYCLES edges in WAIT, and the
// memory access happens on the edge that enters RESP. RESP holds the
// registered result until the CPU takes it.
module gpp16_mem_responder
  import gpp16_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  gpp16_mem_responder_if.slave  bus,
  output state_t                dbg_state
);

  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              rd_sel_q;   // 1 = present RAM read data, 0 = present zero

  logic              accept;
  logic              fire;       // memory access edge (entry into RESP)
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              in_range;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // With zero wait states the access happens on the acceptance edge itself,
  // so in IDLE the operation is taken straight from the bus; otherwise it
  // comes from the latched copy.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    fire          = 1'b0;
    op_we         = we_q;
    op_addr       = addr_q;
    op_wdata      = wdata_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        op_we         = bus.req_we;
        op_addr       = bus.req_addr;
        op_wdata      = bus.req_wdata;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_INIT == 4'd0) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          fire    = 1'b1;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // No address wrap: anything at or above DEPTH is an error and never
  // reaches the array. Reset blocks the access even on the entry edge.
  assign in_range = ({1'b0, op_addr} < DEPTH_L);
  assign ram_en   = fire && in_range && !rst;
  assign ram_we   = ram_en && op_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (fire) begin
        err_q    <= !in_range;
        rd_sel_q <= in_range && !op_we;
      end else if (state_q == RESP && bus.rsp_ready) begin
        err_q    <= 1'b0;
        rd_sel_q <= 1'b0;
      end
    end
  end

  gpp16_sp_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (op_addr),
    .wdata (op_wdata),
    .rdata (ram_rdata)
  );

  // Both terms are registers, so the response payload is stable through RESP.
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rd_sel_q ? ram_rdata : '0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_gpp16_mem_responder.sv
// tb_gpp16_mem_responder -- self-checking bench for gpp16_mem_responder.
// Two instances: dut 0 with WAIT_CYCLES=2, dut 1 with WAIT_CYCLES=0.
// Expected responses come from a word-array memory model and the rule
// "first response visible WAIT_CYCLES edges after the acceptance edge".
module tb_gpp16_mem_responder;
  import gpp16_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  gpp16_mem_responder_if #(.ADDR_W(AW)) bus0 ();
  gpp16_mem_responder_if #(.ADDR_W(AW)) bus1 ();

  logic          req_valid [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [15:0]   req_wdata [2];
  logic          rsp_ready [2];
  logic          req_ready_o [2];
  logic          rsp_valid_o [2];
  logic [15:0]   rsp_rdata_o [2];
  logic          rsp_err_o   [2];
  state_t        st [2];

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_we    = req_we[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus0.req_wdata = req_wdata[0];
  assign bus0.rsp_ready = rsp_ready[0];
  assign bus1.req_valid = req_valid[1];
  assign bus1.req_we    = req_we[1];
  assign bus1.req_addr  = req_addr[1];
  assign bus1.req_wdata = req_wdata[1];
  assign bus1.rsp_ready = rsp_ready[1];

  assign req_ready_o[0] = bus0.req_ready;
  assign rsp_valid_o[0] = bus0.rsp_valid;
  assign rsp_rdata_o[0] = bus0.rsp_rdata;
  assign rsp_err_o[0]   = bus0.rsp_err;
  assign req_ready_o[1] = bus1.req_ready;
  assign rsp_valid_o[1] = bus1.rsp_valid;
  assign rsp_rdata_o[1] = bus1.rsp_rdata;
  assign rsp_err_o[1]   = bus1.rsp_err;

  gpp16_mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus0.slave),
    .dbg_state (st[0])
  );

  gpp16_mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1.slave),
    .dbg_state (st[1])
  );

  // ---------------- reference model / scoreboard ----------------
  int          wait_cycles [2] = '{2, 0};
  logic [15:0] model [2][DEPTH];
  logic [16:0] exp_q [$];        // {err, rdata} per issued request
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one request on dut d and follow it to completion. Called at a
  // negedge with the dut idle; returns at a negedge with the dut idle.
  //   hold    : cycles rsp_ready stays low once the response is visible
  //   early   : rsp_ready held high from acceptance onward
  //   overlap : req_valid raised on the edge the response completes
  task automatic txn(input int d, input bit we, input logic [AW-1:0] addr,
                     input logic [15:0] wdata, input int hold, input bit early,
                     input bit overlap);
    logic [16:0] exp;
    bit          err;
    int          lat;
    err = (int'(addr) >= DEPTH);
    exp = {err, (!we && !err) ? model[d][addr] : 16'h0000};
    if (we && !err) model[d][addr] = wdata;
    exp_q.push_back(exp);

    check("req_ready_idle", 32'(req_ready_o[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = early;
    @(posedge clk);
    @(negedge clk);
    // request is latched; scramble the request lines to prove it
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom_range(0, 1));
    req_addr[d]  = AW'($urandom_range(0, 255));
    req_wdata[d] = 16'($urandom_range(0, 65535));
    lat = 0;
    while (!rsp_valid_o[d] && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    exp = exp_q.pop_front();
    check("latency", 32'(lat), 32'(wait_cycles[d]));
    check("rsp_err", 32'(rsp_err_o[d]), 32'(exp[16]));
    check("rsp_rdata", 32'(rsp_rdata_o[d]), 32'(exp[15:0]));
    check("req_ready_resp", 32'(req_ready_o[d]), 32'd0);
    if (!early) begin
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid_o[d]), 32'd1);
        check("hold_rdata", 32'(rsp_rdata_o[d]), 32'(exp[15:0]));
        check("hold_err", 32'(rsp_err_o[d]), 32'(exp[16]));
        check("hold_req_ready", 32'(req_ready_o[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
    end
    req_valid[d] = overlap;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    check("rsp_valid_done", 32'(rsp_valid_o[d]), 32'd0);
    check("req_ready_done", 32'(req_ready_o[d]), 32'd1);
    if (overlap) check("no_accept_on_done", 32'(st[d]), 32'(IDLE));
  endtask

  // Start a store of 16'h5555 to 0x20 on dut 0, then reset k edges after
  // the acceptance edge (k=2 lands on the edge that would write memory).
  task automatic reset_in_wait(input int k);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = AW'(8'h20);
    req_wdata[0] = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("mid_rst_in_wait", 32'(st[0]), 32'(WAIT));
    repeat (k - 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", 32'(st[0]), 32'(IDLE));
    check("mid_rst_rsp_valid", 32'(rsp_valid_o[0]), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready_o[0]), 32'd1);
    check("mid_rst_rdata", 32'(rsp_rdata_o[0]), 32'd0);
    check("mid_rst_err", 32'(rsp_err_o[0]), 32'd0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_valid_o[0]), 32'd0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [AW-1:0] a;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state of both instances
    for (int d = 0; d < 2; d++) begin
      check("rst_state", 32'(st[d]), 32'(IDLE));
      check("rst_req_ready", 32'(req_ready_o[d]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid_o[d]), 32'd0);
      check("rst_rdata", 32'(rsp_rdata_o[d]), 32'd0);
      check("rst_err", 32'(rsp_err_o[d]), 32'd0);
    end

    // fill every implemented word of dut 0 with known data
    for (int i = 0; i < DEPTH; i++) begin
      txn(0, 1'b1, AW'(i), 16'($urandom_range(0, 65535)), 0, 1'b0, 1'b0);
    end

    // store BEEF to 0x10 and load it back
    txn(0, 1'b1, AW'(8'h10), 16'hBEEF, 0, 1'b0, 1'b0);
    txn(0, 1'b0, AW'(8'h10), 16'h0000, 0, 1'b0, 1'b0);

    // backpressure for 5 cycles, then a completion with req_valid raised
    txn(0, 1'b0, AW'(8'h10), 16'h0000, 5, 1'b0, 1'b0);
    txn(0, 1'b0, AW'(8'h10), 16'h0000, 2, 1'b0, 1'b1);

    // rsp_ready held high through IDLE/WAIT
    txn(0, 1'b0, AW'(8'h10), 16'h0000, 0, 1'b1, 1'b0);

    // out of range: store and load at DEPTH and at the top address
    txn(0, 1'b1, AW'(8'hC0), 16'h1234, 0, 1'b0, 1'b0);
    txn(0, 1'b0, AW'(8'hC0), 16'h0000, 1, 1'b0, 1'b0);
    txn(0, 1'b1, AW'(8'hFF), 16'hA5A5, 0, 1'b0, 1'b0);
    txn(0, 1'b0, AW'(8'hFF), 16'h0000, 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      txn(0, 1'b0, AW'(i), 16'h0000, 0, 1'b0, 1'b0);
    end

    // reset while a store to 0x20 is waiting
    reset_in_wait(1);
    txn(0, 1'b0, AW'(8'h20), 16'h0000, 0, 1'b0, 1'b0);
    reset_in_wait(2);
    txn(0, 1'b0, AW'(8'h20), 16'h0000, 0, 1'b0, 1'b0);

    // zero wait states on dut 1: store then load back
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      txn(1, 1'b1, a, 16'($urandom_range(0, 65535)), 0, 1'b0, 1'b0);
      txn(1, 1'b0, a, 16'h0000, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end
    txn(1, 1'b1, AW'(8'hC5), 16'h7777, 0, 1'b0, 1'b0);
    txn(1, 1'b0, AW'(8'hC5), 16'h0000, 0, 1'b0, 1'b0);

    // random mix on dut 0
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(DEPTH, 255));
      else                           a = AW'($urandom_range(0, DEPTH - 1));
      txn(0, 1'($urandom_range(0, 1)), a, 16'($urandom_range(0, 65535)),
          $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
